mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, SHALL set the maximum consecutive grant cycles before forced rotation (legal range 1..255).
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Port req  input  8  SHALL carry per-requester requests; bit i = requester i = 8:1 mux data input i (a=0 ... h=7).
REQ-005 Port gnt  output  8  SHALL be the registered one-hot (or all-zero) grant vector.
REQ-006 Port sel0  output  1  SHALL be bit 0 of the granted index, wired to the mux sel0.
REQ-007 Port sel1  output  1  SHALL be bit 1 of the granted index, wired to the mux sel1.
REQ-008 Port sel2  output  1  SHALL be bit 2 of the granted index, wired to the mux sel2.
REQ-009 Port busy  output  1  SHALL equal the OR of gnt.

Function
REQ-010 Two states SHALL exist: IDLE (gnt=0) and GRANT (exactly one gnt bit set); all outputs SHALL be registered.
REQ-011 A 3-bit rotate pointer ptr SHALL hold the search start; search order ptr, ptr+1, ..., ptr+7 (mod 8).
REQ-012 IDLE: when any req bit is 1 at an edge, that edge SHALL grant the first set bit in search order and enter GRANT (latency 1 cycle, req sampled -> gnt visible).
REQ-013 Every new grant to index k SHALL set ptr=(k+1) mod 8, set {sel2,sel1,sel0}=k, and clear hold_cnt to 0.
REQ-014 GRANT with req[owner]=1: hold_cnt SHALL increment each cycle, saturating at MAX_HOLD-1.
REQ-015 GRANT, req[owner]=0 sampled, other req pending: the same edge SHALL grant the next requester in search order; no idle cycle.
REQ-016 GRANT, req[owner]=0, no other req: the edge SHALL enter IDLE with gnt=0; sel0..sel2 SHALL hold the last granted index.
REQ-017 Preemption: when hold_cnt=MAX_HOLD-1 and any other req bit is 1, the next edge SHALL rotate grant per REQ-013 even though req[owner]=1.
REQ-018 When hold_cnt=MAX_HOLD-1 and no other req pending, owner SHALL keep the grant indefinitely (no gap, no re-grant glitch).
REQ-019 Owner re-requests are excluded from the rotation search (ptr starts past owner); owner SHALL be re-granted only when no other req is set.
REQ-020 gnt SHALL never have more than one bit set; sel0..sel2 SHALL always match the set bit while busy=1.
REQ-021 MAX_HOLD=1 SHALL rotate every cycle while two or more requesters are active.

Reset
REQ-022 rst_n=0 SHALL immediately, without a clock edge, force gnt=0, busy=0, sel0=sel1=sel2=0, ptr=0, hold_cnt=0, state IDLE.
REQ-023 Reset mid-grant SHALL abandon the grant; the first edge after rst_n rises SHALL arbitrate from ptr=0 as in REQ-012.

Verification
REQ-024 Reset, then req=8'h01 -> one edge later gnt=8'h01, sel2..sel0=000, busy=1.
REQ-025 MAX_HOLD=4, req=8'hFF constant -> gnt walks 01,02,04,...,80,01, each held exactly 4 cycles; sel tracks 0..7.
REQ-026 req=8'h05 from reset -> gnt=8'h01; drop req[0] -> same edge gnt=8'h04, sel2..sel0=010; drop req[2] -> gnt=0, busy=0, sel stays 010.
REQ-027 MAX_HOLD=4, only req[3] held 20 cycles -> gnt=8'h08 continuously, no gap; then raise req[6] with hold saturated -> next edge gnt=8'h40.
REQ-028 Grant active on index 5, pulse rst_n low between edges -> gnt=0 and sel=000 immediately; release with req=8'h80 -> gnt=8'h80, sel=111.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select lines of an 8:1 mux.
// One owner at a time. The owner is preempted after MAX_HOLD consecutive
// grant cycles if another requester is waiting. Every output is a flop.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       sel0,
  output logic       sel1,
  output logic       sel2,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] sel;
  logic [7:0] hold_cnt;

  logic [7:0] cand;
  logic [2:0] pick_idx;
  logic       pick_vld;
  logic       owner_req;
  logic       do_grant;
  logic       do_release;

  assign sel0 = sel[0];
  assign sel1 = sel[1];
  assign sel2 = sel[2];

  // While granted, the owner is masked out of the search. ptr already sits
  // one past the owner, so the owner would be the last choice anyway.
  always_comb begin
    cand      = (state == GRANT) ? (req & ~gnt) : req;
    owner_req = (state == GRANT) && |(req & gnt);
  end

  // First candidate in search order ptr, ptr+1, ..., ptr+7 (mod 8).
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr;
    for (int i = 0; i < 8; i++) begin
      if (!pick_vld && cand[ptr + 3'(i)]) begin
        pick_vld = 1'b1;
        pick_idx = ptr + 3'(i);
      end
    end
  end

  // A new grant is issued in three cases: from idle, when the owner drops
  // its request, or when the owner has used up its hold budget.
  // A release happens when the owner drops its request and nobody else is
  // waiting.
  always_comb begin
    do_grant   = pick_vld && ((state == IDLE) || !owner_req || (hold_cnt == HOLD_MAX));
    do_release = (state == GRANT) && !owner_req && !pick_vld;
  end

  // Arbiter FSM: the grant, the select lines, the pointer and the hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      if (do_grant) begin
        state    <= GRANT;
        gnt      <= 8'd1 << pick_idx;
        sel      <= pick_idx;
        busy     <= 1'b1;
        ptr      <= pick_idx + 3'd1;
        hold_cnt <= '0;
      end else begin
        case (state)
          IDLE: ;
          GRANT: begin
            if (do_release) begin
              // sel keeps the last index so the mux input stays stable
              state    <= IDLE;
              gnt      <= '0;
              busy     <= 1'b0;
              hold_cnt <= '0;
            end else if (hold_cnt < HOLD_MAX) begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with MAX_HOLD=4.
// Checks use the packed word {busy, sel2, sel1, sel0, gnt[7:0]}.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] gnt;
  logic       sel0, sel1, sel2, busy;

  int n_cmp = 0;
  int n_bad = 0;

  mux_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .sel0(sel0), .sel1(sel1), .sel2(sel2), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] obs();
    return {busy, sel2, sel1, sel0, gnt};
  endfunction

  // Build the expected word for a grant to index k.
  function automatic logic [11:0] g(input int k);
    logic [7:0] one;
    one = 8'd1 << k;
    return {1'b1, 3'(k), one};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset between clock edges, check outputs at once, then release.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    chk(tag, obs(), 12'h000);
    rst_n = 1'b1;
  endtask

  initial begin
    #3;
    chk("reset_state", obs(), 12'h000);
    rst_n = 1'b1;

    // Single requester 0
    req = 8'h01;
    step();
    chk("single_req0", obs(), g(0));
    req = 8'h00;
    step();
    chk("release_idle", obs(), 12'h000);

    // Hand-off without a gap, then idle with the select lines held
    do_reset("reset_again");
    req = 8'h05;
    step();
    chk("h05_first", obs(), g(0));
    req = 8'h04;
    step();
    chk("handoff_2", obs(), g(2));
    req = 8'h00;
    step();
    chk("idle_sel_hold", obs(), {1'b0, 3'b010, 8'h00});

    // All requesters active: each index is held for exactly 4 cycles
    do_reset("reset_walk");
    req = 8'hFF;
    step();
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("walk_k%0d_c%0d", k, c), obs(), g(k));
        step();
      end
    end
    chk("walk_wrap", obs(), g(0));

    // Lone owner saturates its hold count and keeps the grant
    do_reset("reset_hold");
    req = 8'h08;
    step();
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("hold3_c%0d", c), obs(), g(3));
      step();
    end
    req = 8'h48;
    step();
    chk("preempt_to6", obs(), g(6));
    // Requester 6 owns the grant for 4 cycles, then it rotates back to 3
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("own6_c%0d", c), obs(), g(6));
    end
    step();
    chk("rotate_back3", obs(), g(3));

    // Reset asserted while a grant is active
    do_reset("reset_pre5");
    req = 8'h20;
    step();
    chk("grant5", obs(), g(5));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_midgrant", obs(), 12'h000);
    req = 8'h80;
    rst_n = 1'b1;
    step();
    chk("after_reset_7", obs(), g(7));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
